fe_mem_initiator: RTL and testbench

//  Initiator side of the alternating fetch/execute main-memory port. Mirrors the memory's E phase.

---
 rtl/fe_pkg.sv | 35 +++
 rtl/fe_regfile.sv | 37 +++
 rtl/fe_mem_initiator.sv | 157 +++++++++++++++
 tb/tb_fe_mem_initiator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared definitions for the fetch/execute memory initiator:
// opcodes, phase encoding and instruction field helpers.
package fe_pkg;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_e;

    function automatic logic [5:0] f_op(input logic [31:0] i);
        return i[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] i);
        return i[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] i);
        return i[20:16];
    endfunction

    function automatic logic [31:0] f_simm(input logic [31:0] i);
        return {{16{i[15]}}, i[15:0]};
    endfunction

    function automatic logic [25:0] f_tgt(input logic [31:0] i);
        return i[25:0];
    endfunction

endpackage

// File: rtl/fe_regfile.sv
// Local register file: two async read ports, one debug read,
// one sync write port; r0 is hardwired to zero.
module fe_regfile #(
    parameter int RF_DEPTH = 8,
    localparam int AW = $clog2(RF_DEPTH)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    input  logic [AW-1:0] ra_dbg,
    output logic [31:0]   rd_a,
    output logic [31:0]   rd_b,
    output logic [31:0]   rd_dbg,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd
);

    logic [31:0] rf [RF_DEPTH];

    // Storage: cleared by reset, writes to r0 dropped.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            rf[wa] <= wd;
        end
    end

    assign rd_a   = (ra_a   == '0) ? '0 : rf[ra_a];
    assign rd_b   = (ra_b   == '0) ? '0 : rf[ra_b];
    assign rd_dbg = (ra_dbg == '0) ? '0 : rf[ra_dbg];

endmodule

// File: rtl/fe_mem_initiator.sv
// Initiator for the alternating fetch/execute memory port.
// Optional FE_INIT_RETIRE_CNT_EN adds the retire_cnt output.
module fe_mem_initiator
    import fe_pkg::*;
#(
    parameter int          RF_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        mem_e,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_iout,
    input  logic [31:0] mem_mout,
    output logic [31:0] next_pc,
    output logic [31:0] data_addr,
    output logic [31:0] data_out,
    output logic        store,
    output logic        halted,
    output logic        err_phase,
    output logic        err_align,
    input  logic [2:0]  dbg_sel,
    output logic [31:0] dbg_data
`ifdef FE_INIT_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam int AW = $clog2(RF_DEPTH);

    phase_e state_q, state_d;

    logic [31:0]   addr_q, dout_q;
    logic          pend_q;
    logic [AW-1:0] pend_rt_q;

    logic [5:0]    op;
    logic [4:0]    rs5, rt5;
    logic [AW-1:0] rs_idx, rt_idx, dbg_idx;
    logic [31:0]   rs_val, rt_val, ea;
    logic          is_lw, is_sw, is_j, is_halt;
    logic          mismatch, exec_ok, fetch_ok;

    assign op      = f_op(mem_iout);
    assign rs5     = f_rs(mem_iout);
    assign rt5     = f_rt(mem_iout);
    assign rs_idx  = rs5[AW-1:0];
    assign rt_idx  = rt5[AW-1:0];
    assign dbg_idx = AW'(dbg_sel);

    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_j    = (op == OP_J);
    assign is_halt = (op == OP_HALT);

    assign ea = rs_val + f_simm(mem_iout);

    assign mismatch = !halted && ((state_q == EXEC) != mem_e);
    assign exec_ok  = !halted && (state_q == EXEC) && mem_e;
    assign fetch_ok = !halted && (state_q == FETCH) && !mem_e;

    fe_regfile #(.RF_DEPTH(RF_DEPTH)) u_rf (
        .clk    (clk),
        .Reset  (Reset),
        .ra_a   (rs_idx),
        .ra_b   (rt_idx),
        .ra_dbg (dbg_idx),
        .rd_a   (rs_val),
        .rd_b   (rt_val),
        .rd_dbg (dbg_data),
        .we     (fetch_ok && pend_q),
        .wa     (pend_rt_q),
        .wd     (mem_mout)
    );

    // Phase register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next phase and memory-facing combinational outputs.
    // In sync, toggling equals ~mem_e; on a mismatch the same
    // rule realigns the FSM to the memory.
    always_comb begin
        state_d   = state_q;
        store     = 1'b0;
        data_addr = addr_q;
        data_out  = dout_q;
        if (!halted) begin
            state_d = mem_e ? FETCH : EXEC;
        end
        if (exec_ok && (is_lw || is_sw)) begin
            data_addr = ea;
        end
        if (exec_ok && is_sw) begin
            data_out = rt_val;
            store    = 1'b1;
        end
    end

    // Next-PC and halt tracking, updated at the end of EXEC.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            next_pc <= RESET_PC;
            halted  <= 1'b0;
        end else if (exec_ok) begin
            unique case (1'b1)
                is_j:    next_pc <= {mem_pc[31:28],
                                     f_tgt(mem_iout), 2'b00};
                is_halt: halted  <= 1'b1;
                default: next_pc <= mem_pc + 32'd4;
            endcase
        end
    end

    // Held address/data and the pending load write-back.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            addr_q    <= '0;
            dout_q    <= '0;
            pend_q    <= 1'b0;
            pend_rt_q <= '0;
        end else if (exec_ok) begin
            addr_q <= data_addr;
            dout_q <= data_out;
            if (is_lw) begin
                pend_q    <= 1'b1;
                pend_rt_q <= rt_idx;
            end
        end else if (fetch_ok) begin
            pend_q <= 1'b0;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            err_phase <= 1'b0;
            err_align <= 1'b0;
        end else begin
            if (mismatch) err_phase <= 1'b1;
            if (exec_ok && (is_lw || is_sw) && (ea[1:0] != 2'b00))
                err_align <= 1'b1;
        end
    end

`ifdef FE_INIT_RETIRE_CNT_EN
    // Retired-instruction counter, HALT included.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)        retire_cnt <= '0;
        else if (exec_ok) retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fe_mem_initiator.sv
// Directed bench for fe_mem_initiator: inputs change 1ns after
// posedge, outputs are checked on the following negedge.
module tb_fe_mem_initiator;

    logic        clk = 1'b0;
    logic        Reset;
    logic        mem_e;
    logic [31:0] mem_pc, mem_iout, mem_mout;
    logic [31:0] next_pc, data_addr, data_out;
    logic        store, halted, err_phase, err_align;
    logic [2:0]  dbg_sel;
    logic [31:0] dbg_data;
`ifdef FE_INIT_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] I_SW0   = 32'hAC000010;
    localparam logic [31:0] I_LW1   = 32'h8C010008;
    localparam logic [31:0] I_SW1   = 32'hAC010010;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_J40   = 32'h08000010;
    localparam logic [31:0] I_LW2   = 32'h8C020004;
    localparam logic [31:0] I_SW13  = 32'hAC000013;
    localparam logic [31:0] I_HALT  = 32'hFC000000;

    fe_mem_initiator dut (
        .clk       (clk),
        .Reset     (Reset),
        .mem_e     (mem_e),
        .mem_pc    (mem_pc),
        .mem_iout  (mem_iout),
        .mem_mout  (mem_mout),
        .next_pc   (next_pc),
        .data_addr (data_addr),
        .data_out  (data_out),
        .store     (store),
        .halted    (halted),
        .err_phase (err_phase),
        .err_align (err_align),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
`ifdef FE_INIT_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One memory cycle: wait for the edge, present the phase,
    // then stop on the negedge so the caller can check.
    task automatic drive(input logic        e,
                         input logic [31:0] pc,
                         input logic [31:0] iout,
                         input logic [31:0] mout);
        @(posedge clk);
        #1;
        mem_e    = e;
        mem_pc   = pc;
        mem_iout = iout;
        mem_mout = mout;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_next_pc"}, next_pc, 32'h0);
        chk({pfx, "_addr"}, data_addr, 32'h0);
        chk({pfx, "_dout"}, data_out, 32'h0);
        chk({pfx, "_store"}, {31'h0, store}, 32'h0);
        chk({pfx, "_halted"}, {31'h0, halted}, 32'h0);
        chk({pfx, "_errph"}, {31'h0, err_phase}, 32'h0);
        chk({pfx, "_erral"}, {31'h0, err_align}, 32'h0);
        chk({pfx, "_dbg"}, dbg_data, 32'h0);
`ifdef FE_INIT_RETIRE_CNT_EN
        chk({pfx, "_retire"}, retire_cnt, 32'h0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset    = 1'b1;
        mem_e    = 1'b0;
        mem_pc   = '0;
        mem_iout = '0;
        mem_mout = '0;
        dbg_sel  = 3'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        Reset = 1'b0;
        // Next edge consumes the idle inputs as the first fetch.

        drive(1'b1, 32'h0, I_SW0, '0);
        chk("sw0_store", {31'h0, store}, 32'h1);
        chk("sw0_addr", data_addr, 32'h10);
        chk("sw0_dout", data_out, 32'h0);

        drive(1'b0, '0, '0, '0);
        chk("sw0_npc", next_pc, 32'h4);
        chk("f1_store", {31'h0, store}, 32'h0);
        chk("f1_addr_hold", data_addr, 32'h10);

        drive(1'b1, 32'h4, I_LW1, '0);
        chk("lw1_addr", data_addr, 32'h8);
        chk("lw1_store", {31'h0, store}, 32'h0);

        drive(1'b0, '0, '0, 32'hDEADBEEF);
        chk("lw1_early", dbg_data, 32'h0);
        chk("lw1_npc", next_pc, 32'h8);

        drive(1'b1, 32'h8, I_SW1, '0);
        chk("lw1_wb", dbg_data, 32'hDEADBEEF);
        chk("use_dout", data_out, 32'hDEADBEEF);
        chk("use_store", {31'h0, store}, 32'h1);

        drive(1'b0, '0, '0, '0);
        chk("sw1_npc", next_pc, 32'hC);

        drive(1'b1, 32'hFFFFFFFC, I_NOP, '0);
        chk("nop_addr_hold", data_addr, 32'h10);

        drive(1'b0, '0, '0, '0);
        chk("wrap_npc", next_pc, 32'h0);

        drive(1'b1, 32'hC, I_J40, '0);
        drive(1'b0, '0, '0, '0);
        chk("j_npc", next_pc, 32'h40);

        drive(1'b1, 32'h40, I_LW2, '0);
        chk("lw2_addr", data_addr, 32'h4);

        drive(1'b0, '0, '0, 32'h12345678);
        dbg_sel = 3'd2;
        drive(1'b1, 32'h44, I_NOP, '0);
        chk("lw2_wb", dbg_data, 32'h12345678);
        chk("errph_clean", {31'h0, err_phase}, 32'h0);

        drive(1'b1, 32'h48, I_SW0, '0);
        chk("mis_store", {31'h0, store}, 32'h0);
        chk("mis_addr", data_addr, 32'h4);

        drive(1'b0, '0, '0, '0);
        chk("mis_errph", {31'h0, err_phase}, 32'h1);
        chk("mis_npc", next_pc, 32'h48);

        drive(1'b1, 32'h48, I_SW13, '0);
        chk("al_store", {31'h0, store}, 32'h1);
        chk("al_addr", data_addr, 32'h13);
        chk("al_pre", {31'h0, err_align}, 32'h0);

        drive(1'b0, '0, '0, '0);
        chk("al_erral", {31'h0, err_align}, 32'h1);
        chk("resync_npc", next_pc, 32'h4C);

        drive(1'b1, 32'h4C, I_HALT, '0);
        chk("halt_store", {31'h0, store}, 32'h0);

        drive(1'b0, '0, '0, '0);
        chk("halted", {31'h0, halted}, 32'h1);
        chk("halt_npc", next_pc, 32'h4C);
`ifdef FE_INIT_RETIRE_CNT_EN
        chk("retire", retire_cnt, 32'd9);
`endif

        drive(1'b1, 32'h4C, I_SW0, '0);
        chk("hsw_store", {31'h0, store}, 32'h0);
        chk("hsw_npc", next_pc, 32'h4C);

        #1 Reset = 1'b1;
        #1 chk_reset_vals("hrst");
        mem_e    = 1'b0;
        mem_iout = '0;
        #1 Reset = 1'b0;

        drive(1'b1, 32'h0, I_SW0, '0);
        chk("rsw_store", {31'h0, store}, 32'h1);
        #1 Reset = 1'b1;
        #1;
        chk("arst_store", {31'h0, store}, 32'h0);
        chk("arst_addr", data_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
